// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Glyphs are common-anode codes {dp,g..a}, active low, with the DP segment off.
package seg7_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBlank = 2'd1,
    StShow  = 2'd2
  } state_e;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Index 0 is the rightmost element; GLYPHS[n] is the glyph for hex digit n.
  localparam logic [15:0][7:0] GLYPHS = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Host-side and display-side signals of the scan controller.
// The master drives the value/mask; the slave (controller) drives the pins.
interface seg7_scan_ctrl_if #(
  parameter int unsigned DIGITS = 8
);
  logic [4*DIGITS-1:0] data_in;
  logic                load;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   digit_en;
  logic [DIGITS-1:0]   an;
  logic [7:0]          seg;
  logic                frame_done;

  modport master (
    output data_in, load, dp_in, digit_en,
    input  an, seg, frame_done
  );

  modport slave (
    input  data_in, load, dp_in, digit_en,
    output an, seg, frame_done
  );

endinterface

// File: rtl/led_seg7.sv
// Combinational hex-to-7-segment decoder for a single common-anode digit.
module led_seg7
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [7:0] seg_o,
  output logic       an_o
);

  assign seg_o = GLYPHS[hex_i];
  assign an_o  = 1'b0;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit common-anode display.
// Each enabled digit is blanked, then lit; the display copy only changes at frame edges.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic            clk,
  input  logic            rst_n,
  seg7_scan_ctrl_if.slave bus
);

  localparam int unsigned DataW  = 4 * DIGITS;
  localparam int unsigned MaxCyc = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  localparam int unsigned IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Lowest enabled digit strictly above cur, else the lowest enabled digit overall.
  function automatic logic [IdxW-1:0] next_en(input logic [DIGITS-1:0] mask,
                                              input logic [IdxW-1:0]   cur);
    logic [IdxW-1:0] first;
    logic [IdxW-1:0] above;
    logic            have_first;
    logic            have_above;
    first      = '0;
    above      = '0;
    have_first = 1'b0;
    have_above = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (mask[i] && !have_first) begin
        first      = IdxW'(i);
        have_first = 1'b1;
      end
      if (mask[i] && !have_above && (IdxW'(i) > cur)) begin
        above      = IdxW'(i);
        have_above = 1'b1;
      end
    end
    return have_above ? above : first;
  endfunction

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DataW-1:0]  shadow_q, shadow_d;
  logic [DataW-1:0]  disp_q, disp_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [7:0]        seg_q, seg_d;
  logic              frame_done_q, frame_done_d;

  logic [IdxW-1:0]   idx_next;
  logic [IdxW-1:0]   idx_lowest;
  logic [3:0]        nibble;
  logic [7:0]        dec_seg;
  logic              unused_dec_an;

  assign idx_next   = next_en(bus.digit_en, idx_q);
  assign idx_lowest = next_en(bus.digit_en, IdxW'(DIGITS - 1));
  assign nibble     = disp_q[{idx_d, 2'b00} +: 4];

  led_seg7 u_dec (
    .hex_i (nibble),
    .seg_o (dec_seg),
    .an_o  (unused_dec_an)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    shadow_d     = bus.load ? bus.data_in : shadow_q;
    disp_d       = disp_q;
    frame_done_d = 1'b0;
    if (bus.digit_en == '0) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StBlank;
          idx_d   = idx_lowest;
          cnt_d   = '0;
          disp_d  = shadow_q;
        end
        StBlank: begin
          if (cnt_q == CntW'(BLANK_CYC - 1)) begin
            state_d = StShow;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StShow: begin
          if (cnt_q == CntW'(SCAN_DIV - 1)) begin
            state_d = StBlank;
            cnt_d   = '0;
            idx_d   = idx_next;
            // A wrapping search closes the frame; load on this edge lands next frame.
            if (idx_next <= idx_q) begin
              disp_d       = shadow_q;
              frame_done_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StBlank;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are computed from the next state so the pins track state_q exactly.
  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    if (state_d == StShow) begin
      an_d[idx_d] = 1'b0;
      seg_d       = {~bus.dp_in[idx_d] & dec_seg[7], dec_seg[6:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StBlank;
      idx_q        <= '0;
      cnt_q        <= '0;
      shadow_q     <= '0;
      disp_q       <= '0;
      an_q         <= '1;
      seg_q        <= SEG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      disp_q       <= disp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with SCAN_DIV=4, BLANK_CYC=2, DIGITS=8.
module tb_seg7_scan_ctrl;

  localparam int unsigned DIGITS    = 8;
  localparam int unsigned SCAN_DIV  = 4;
  localparam int unsigned BLANK_CYC = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg7_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

  seg7_scan_ctrl #(
    .DIGITS    (DIGITS),
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic [7:0] cap_an  [128];
  logic [7:0] cap_seg [128];
  logic       cap_fd  [128];
  logic [7:0] exp_an  [128];
  logic [7:0] exp_seg [128];
  logic       exp_fd  [128];
  int         exp_len;
  bit         found;

  task automatic add_sample(input logic [7:0] a, input logic [7:0] s, input logic f);
    exp_an[exp_len]  = a;
    exp_seg[exp_len] = s;
    exp_fd[exp_len]  = f;
    exp_len++;
  endtask

  // One digit slot: 4 lit cycles then 2 blank cycles, frame_done on the first blank if last.
  task automatic add_digit(input int k, input logic [31:0] data, input logic dp,
                           input logic last);
    logic [7:0] a;
    logic [7:0] g;
    logic [3:0] nib;
    a   = ~(8'h01 << k);
    nib = data[4*k +: 4];
    g   = glyph[nib];
    repeat (SCAN_DIV) add_sample(a, {~dp, g[6:0]}, 1'b0);
    add_sample(8'hFF, 8'hFF, last);
    add_sample(8'hFF, 8'hFF, 1'b0);
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      cap_an[i]  = bus.an;
      cap_seg[i] = bus.seg;
      cap_fd[i]  = bus.frame_done;
      @(negedge clk);
    end
  endtask

  // Advance to the first lit cycle of digit k that follows a blank cycle.
  task automatic sync_show(input int k, output bit ok);
    logic [7:0] tgt;
    logic [7:0] prev;
    tgt  = ~(8'h01 << k);
    ok   = 1'b0;
    prev = bus.an;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.an === tgt && prev === 8'hFF) begin
        ok = 1'b1;
        break;
      end
      prev = bus.an;
    end
  endtask

  task automatic pulse_load(input logic [31:0] v);
    bus.data_in = v;
    bus.load    = 1'b1;
    @(negedge clk);
    bus.load    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.load     = 1'b0;
    bus.data_in  = '0;
    bus.dp_in    = '0;
    bus.digit_en = 8'hFF;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.an !== 8'hFF || bus.seg !== 8'hFF || bus.frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: an=%h seg=%h fd=%b, want FF FF 0",
               bus.an, bus.seg, bus.frame_done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.an !== 8'hFF || bus.seg !== 8'hFF || bus.frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_blank: an=%h seg=%h fd=%b, want FF FF 0",
               bus.an, bus.seg, bus.frame_done);
    end
    @(negedge clk);
    checks++;
    if (bus.an !== 8'hFE || bus.seg !== 8'hC0 || bus.frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_digit: an=%h seg=%h fd=%b, want FE C0 0",
               bus.an, bus.seg, bus.frame_done);
    end
  endtask

  task automatic test_scan_all();
    pulse_load(32'h76543210);
    sync_show(7, found);
    sync_show(0, found);
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL scan_all_sync: digit 0 not lit within bound, want lit");
    end
    exp_len = 0;
    for (int k = 0; k < 8; k++) add_digit(k, 32'h76543210, 1'b0, k == 7);
    capture(exp_len);
    for (int i = 0; i < exp_len; i++) begin
      checks++;
      if (cap_an[i] !== exp_an[i] || cap_seg[i] !== exp_seg[i] || cap_fd[i] !== exp_fd[i]) begin
        failures++;
        $display("FAIL scan_all[%0d]: an=%h seg=%h fd=%b, want an=%h seg=%h fd=%b", i,
                 cap_an[i], cap_seg[i], cap_fd[i], exp_an[i], exp_seg[i], exp_fd[i]);
      end
    end
  endtask

  task automatic test_load_mid_frame();
    repeat (8) @(negedge clk);
    pulse_load(32'hFFFFFFFF);
    sync_show(4, found);
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL load_mid_sync: digit 4 not lit within bound, want lit");
    end
    exp_len = 0;
    for (int k = 4; k < 8; k++) add_digit(k, 32'h76543210, 1'b0, k == 7);
    for (int k = 0; k < 8; k++) add_digit(k, 32'hFFFFFFFF, 1'b0, k == 7);
    capture(exp_len);
    for (int i = 0; i < exp_len; i++) begin
      checks++;
      if (cap_an[i] !== exp_an[i] || cap_seg[i] !== exp_seg[i] || cap_fd[i] !== exp_fd[i]) begin
        failures++;
        $display("FAIL load_mid[%0d]: an=%h seg=%h fd=%b, want an=%h seg=%h fd=%b", i,
                 cap_an[i], cap_seg[i], cap_fd[i], exp_an[i], exp_seg[i], exp_fd[i]);
      end
    end
  endtask

  task automatic test_mask_dp();
    bus.digit_en = 8'h05;
    bus.dp_in    = 8'h04;
    sync_show(2, found);
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL mask_dp_sync: digit 2 not lit within bound, want lit");
    end
    exp_len = 0;
    add_digit(2, 32'hFFFFFFFF, 1'b1, 1'b1);
    add_digit(0, 32'hFFFFFFFF, 1'b0, 1'b0);
    add_digit(2, 32'hFFFFFFFF, 1'b1, 1'b1);
    capture(exp_len);
    for (int i = 0; i < exp_len; i++) begin
      checks++;
      if (cap_an[i] !== exp_an[i] || cap_seg[i] !== exp_seg[i] || cap_fd[i] !== exp_fd[i]) begin
        failures++;
        $display("FAIL mask_dp[%0d]: an=%h seg=%h fd=%b, want an=%h seg=%h fd=%b", i,
                 cap_an[i], cap_seg[i], cap_fd[i], exp_an[i], exp_seg[i], exp_fd[i]);
      end
    end
  endtask

  task automatic test_mask_zero();
    sync_show(2, found);
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL mask_zero_sync: digit 2 not lit within bound, want lit");
    end
    @(negedge clk);
    bus.digit_en = 8'h00;
    @(negedge clk);
    exp_len = 0;
    repeat (6) add_sample(8'hFF, 8'hFF, 1'b0);
    capture(exp_len);
    for (int i = 0; i < exp_len; i++) begin
      checks++;
      if (cap_an[i] !== exp_an[i] || cap_seg[i] !== exp_seg[i] || cap_fd[i] !== exp_fd[i]) begin
        failures++;
        $display("FAIL mask_zero_idle[%0d]: an=%h seg=%h fd=%b, want an=%h seg=%h fd=%b", i,
                 cap_an[i], cap_seg[i], cap_fd[i], exp_an[i], exp_seg[i], exp_fd[i]);
      end
    end
    bus.digit_en = 8'h80;
    @(negedge clk);
    exp_len = 0;
    add_sample(8'hFF, 8'hFF, 1'b0);
    add_sample(8'hFF, 8'hFF, 1'b0);
    add_digit(7, 32'hFFFFFFFF, 1'b0, 1'b1);
    add_digit(7, 32'hFFFFFFFF, 1'b0, 1'b1);
    capture(exp_len);
    for (int i = 0; i < exp_len; i++) begin
      checks++;
      if (cap_an[i] !== exp_an[i] || cap_seg[i] !== exp_seg[i] || cap_fd[i] !== exp_fd[i]) begin
        failures++;
        $display("FAIL mask_restore[%0d]: an=%h seg=%h fd=%b, want an=%h seg=%h fd=%b", i,
                 cap_an[i], cap_seg[i], cap_fd[i], exp_an[i], exp_seg[i], exp_fd[i]);
      end
    end
  endtask

  task automatic test_reset_mid_show();
    sync_show(7, found);
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reset_mid_sync: digit 7 not lit within bound, want lit");
    end
    @(negedge clk);
    rst_n        = 1'b0;
    bus.digit_en = 8'hFF;
    bus.dp_in    = 8'h00;
    #1;
    checks++;
    if (bus.an !== 8'hFF || bus.seg !== 8'hFF || bus.frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: an=%h seg=%h fd=%b, want FF FF 0",
               bus.an, bus.seg, bus.frame_done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_len = 0;
    add_sample(8'hFF, 8'hFF, 1'b0);
    add_digit(0, 32'h0, 1'b0, 1'b0);
    add_digit(1, 32'h0, 1'b0, 1'b0);
    capture(exp_len);
    for (int i = 0; i < exp_len; i++) begin
      checks++;
      if (cap_an[i] !== exp_an[i] || cap_seg[i] !== exp_seg[i] || cap_fd[i] !== exp_fd[i]) begin
        failures++;
        $display("FAIL reset_restart[%0d]: an=%h seg=%h fd=%b, want an=%h seg=%h fd=%b", i,
                 cap_an[i], cap_seg[i], cap_fd[i], exp_an[i], exp_seg[i], exp_fd[i]);
      end
    end
  endtask

  task automatic test_load_boundary();
    pulse_load(32'h89ABCDEF);
    sync_show(7, found);
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL boundary_sync7: digit 7 not lit within bound, want lit");
    end
    repeat (SCAN_DIV - 1) @(negedge clk);
    pulse_load(32'h01234567);
    checks++;
    if (bus.an !== 8'hFF || bus.frame_done !== 1'b1) begin
      failures++;
      $display("FAIL boundary_edge: an=%h fd=%b, want FF 1", bus.an, bus.frame_done);
    end
    sync_show(0, found);
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL boundary_sync0: digit 0 not lit within bound, want lit");
    end
    exp_len = 0;
    for (int k = 0; k < 8; k++) add_digit(k, 32'h89ABCDEF, 1'b0, k == 7);
    for (int k = 0; k < 8; k++) add_digit(k, 32'h01234567, 1'b0, k == 7);
    capture(exp_len);
    for (int i = 0; i < exp_len; i++) begin
      checks++;
      if (cap_an[i] !== exp_an[i] || cap_seg[i] !== exp_seg[i] || cap_fd[i] !== exp_fd[i]) begin
        failures++;
        $display("FAIL load_boundary[%0d]: an=%h seg=%h fd=%b, want an=%h seg=%h fd=%b", i,
                 cap_an[i], cap_seg[i], cap_fd[i], exp_an[i], exp_seg[i], exp_fd[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_all();
    test_load_mid_frame();
    test_mask_dp();
    test_mask_zero();
    test_reset_mid_show();
    test_load_boundary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
